// File: rtl/taylor_exp_scaler_if.sv
// taylor_exp_scaler_if: start/abort request, operands and result bundle for the exp scaler
interface taylor_exp_scaler_if #(
  parameter int W = 16
);
  logic start, abort, busy, done, ovf;
  logic signed [W-1:0] x, v, exp_out, distance;
  modport master(output start, abort, x, v, input busy, done, ovf, exp_out, distance);
  modport slave(input start, abort, x, v, output busy, done, ovf, exp_out, distance);
endinterface

// File: rtl/taylor_exp_scaler.sv
// taylor_exp_scaler: distance = exp(x)*v from a truncated Taylor series on one shared multiplier
module taylor_exp_scaler #(
  parameter int W = 16,
  parameter int FRAC = 10,
  parameter int NTERMS = 8
) (
  input logic clk,
  input logic asyncRst,
  taylor_exp_scaler_if.slave bus
);
  localparam int NW = $clog2(NTERMS);
  localparam logic signed [W-1:0] ONE = W'(1 << FRAC);
  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, MUL_X, MUL_C, ACC, SCALE, DONE} state_t;
  state_t state, next;
  logic signed [W-1:0] xr, vr, term, acc, exp_q, dist_q;
  logic signed [W-1:0] ma, mb, mres, sres;
  logic signed [2*W-1:0] prod, sh;
  logic signed [W:0] sum;
  logic [NW-1:0] n;
  logic ovf_q, mov, sov;
  logic signed [W-1:0] recip [NTERMS];
  for (genvar i = 0; i < NTERMS; i++) begin : g_recip
    assign recip[i] = W'((1 << FRAC) / (i == 0 ? 1 : i));
  end
  // shared multiplier with floor shift and saturation, plus saturating series adder
  always_comb begin
    ma = state == SCALE ? acc : term;
    mb = state == MUL_X ? xr : state == MUL_C ? recip[n] : vr;
    prod = ma * mb;
    sh = prod >>> FRAC;
    mov = !(&sh[2*W-1:W-1] || ~|sh[2*W-1:W-1]);
    mres = mov ? (sh[2*W-1] ? MINV : MAXV) : sh[W-1:0];
    sum = {acc[W-1], acc} + {term[W-1], term};
    sov = sum[W] != sum[W-1];
    sres = sov ? (sum[W] ? MINV : MAXV) : sum[W-1:0];
  end
  // state register
  always_ff @(posedge clk or negedge asyncRst)
    if (!asyncRst) state <= IDLE;
    else state <= next;
  // next-state: abort wins over everything, start only counts in IDLE
  always_comb begin
    next = state;
    if (bus.abort) next = IDLE;
    else
      case (state)
        IDLE: next = bus.start ? MUL_X : IDLE;
        MUL_X: next = MUL_C;
        MUL_C: next = ACC;
        ACC: next = n == NW'(NTERMS - 1) ? SCALE : MUL_X;
        SCALE: next = DONE;
        default: next = IDLE;
      endcase
  end
  // status outputs
  always_comb begin
    bus.busy = state != IDLE;
    bus.done = state == DONE;
  end
  // datapath registers; an abort cycle freezes everything so results survive the cancel
  always_ff @(posedge clk or negedge asyncRst)
    if (!asyncRst) begin
      xr <= '0;
      vr <= '0;
      term <= '0;
      acc <= '0;
      exp_q <= '0;
      dist_q <= '0;
      n <= '0;
      ovf_q <= 1'b0;
    end else if (!bus.abort)
      case (state)
        IDLE:
          if (bus.start) begin
            xr <= bus.x;
            vr <= bus.v;
            term <= ONE;
            acc <= ONE;
            n <= NW'(1);
            ovf_q <= 1'b0;
          end
        MUL_X, MUL_C: begin
          term <= mres;
          ovf_q <= ovf_q | mov;
        end
        ACC: begin
          acc <= sres;
          ovf_q <= ovf_q | sov;
          if (n != NW'(NTERMS - 1)) n <= n + 1'b1;
        end
        SCALE: begin
          dist_q <= mres;
          exp_q <= acc;
          ovf_q <= ovf_q | mov;
        end
        default: ;
      endcase
  assign bus.ovf = ovf_q;
  assign bus.exp_out = exp_q;
  assign bus.distance = dist_q;
endmodule

// File: tb/tb_taylor_exp_scaler.sv
// tb_taylor_exp_scaler: directed runs with hand-computed series results, latency, abort and reset checks
module tb_taylor_exp_scaler;
  logic clk = 0, asyncRst = 0;
  int tests = 0, fails = 0;
  int dc, nd, bb;
  taylor_exp_scaler_if #(.W(16)) bus();
  taylor_exp_scaler #(.W(16), .FRAC(10), .NTERMS(8)) dut (.clk(clk), .asyncRst(asyncRst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic run(input int xi, input int vi, input int ab, input int ncyc, input bit extra,
                     output int done_cyc, output int ndone, output int busy_bad);
    bus.x = 16'(xi);
    bus.v = 16'(vi);
    bus.start = 1;
    done_cyc = -1;
    ndone = 0;
    busy_bad = 0;
    @(posedge clk);
    #1 bus.start = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        done_cyc = c;
      end
      if (bus.busy !== (c <= 23 && (ab == 0 || c <= ab))) busy_bad++;
      bus.start = extra && (c == 5 || c == 23);
      bus.abort = c == ab;
    end
    bus.start = 0;
    bus.abort = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 0;
    bus.abort = 0;
    bus.x = 0;
    bus.v = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_exp", bus.exp_out, 0);
    check("rst_dist", bus.distance, 0);
    asyncRst = 1;
    @(negedge clk);
    run(0, 1024, 0, 26, 0, dc, nd, bb);
    check("x0_done_cyc", dc, 23);
    check("x0_ndone", nd, 1);
    check("x0_busy", bb, 0);
    check("x0_exp", bus.exp_out, 1024);
    check("x0_dist", bus.distance, 1024);
    check("x0_ovf", bus.ovf, 0);
    run(1024, 1024, 0, 26, 0, dc, nd, bb);
    check("x1_done_cyc", dc, 23);
    check("x1_exp", bus.exp_out, 2781);
    check("x1_dist", bus.distance, 2781);
    check("x1_ovf", bus.ovf, 0);
    run(-1024, 2048, 0, 26, 0, dc, nd, bb);
    check("xm1_exp", bus.exp_out, 374);
    check("xm1_dist", bus.distance, 748);
    check("xm1_ovf", bus.ovf, 0);
    run(16384, 1024, 0, 26, 0, dc, nd, bb);
    check("x16_exp", bus.exp_out, 32767);
    check("x16_dist", bus.distance, 32767);
    check("x16_ovf", bus.ovf, 1);
    run(0, 1024, 0, 26, 0, dc, nd, bb);
    check("ovf_clear", bus.ovf, 0);
    check("ovf_clear_dist", bus.distance, 1024);
    run(-1024, 2048, 0, 24, 1, dc, nd, bb);
    check("ign_ndone", nd, 1);
    check("ign_done_cyc", dc, 23);
    check("ign_busy", bb, 0);
    run(1024, 1024, 0, 26, 0, dc, nd, bb);
    check("c24_done_cyc", dc, 23);
    check("c24_dist", bus.distance, 2781);
    run(-1024, 2048, 10, 20, 0, dc, nd, bb);
    check("abort_ndone", nd, 0);
    check("abort_busy", bb, 0);
    check("abort_dist", bus.distance, 2781);
    check("abort_exp", bus.exp_out, 2781);
    check("abort_ovf", bus.ovf, 0);
    bus.x = 16384;
    bus.v = 1024;
    bus.start = 1;
    @(posedge clk);
    #1 bus.start = 0;
    repeat (8) @(posedge clk);
    #2 asyncRst = 0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_ovf", bus.ovf, 0);
    check("arst_exp", bus.exp_out, 0);
    check("arst_dist", bus.distance, 0);
    @(negedge clk);
    asyncRst = 1;
    @(negedge clk);
    run(-1024, 2048, 0, 26, 0, dc, nd, bb);
    check("post_done_cyc", dc, 23);
    check("post_exp", bus.exp_out, 374);
    check("post_dist", bus.distance, 748);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
